// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch controller: FSM state
//   encoding, instruction/PC width, sequential PC increment and the default
//   post-reset fetch address.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IDLE  : no memory request outstanding
    // REQ   : request outstanding, returned data goes to the decode slot
    // DRAIN : request outstanding, returned data is wrong-path and dropped
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_adder.sv
// fetch_pc_adder
//   Sequential next-PC: pc_i + 4, wrapping modulo 2^32.
//   Ports:
//     pc_i       current fetch PC
//     pc_next_o  pc_i + PC_INC
module fetch_pc_adder
    import fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] pc_i,
    output logic [INSTR_W-1:0] pc_next_o
);

    // Carry out of bit 31 is dropped, so 32'hFFFF_FFFC wraps to 0.
    assign pc_next_o = pc_i + PC_INC;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences instruction fetch against a variable-latency req/ack
//   instruction memory and presents one registered instruction slot to
//   decode. Honours decode stall and applies branch/jump redirects, dropping
//   the data of any fetch that was in flight when the redirect arrived.
//   Ports:
//     clk, reset        clock; asynchronous active-high reset
//     imem_req/addr     registered fetch request and address (addr stable
//                       while req is high)
//     imem_ack/rdata    memory completion and instruction word (same cycle)
//     redirect_valid/pc one-cycle redirect pulse and target (bits [1:0] dropped)
//     stall             decode cannot accept the slot this cycle
//     instr_valid/instr/instr_pc  decode slot
//     pc                next address to fetch
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] instr_pc,
    output logic [INSTR_W-1:0] pc
);

    fetch_state_e       state_q;
    logic               imem_req_q;
    logic [INSTR_W-1:0] imem_addr_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_pc_q;
    logic [INSTR_W-1:0] pc_q;

    logic [INSTR_W-1:0] pc_inc_d;
    logic [INSTR_W-1:0] redirect_tgt_d;
    logic               unused_redirect_lsbs;

    fetch_pc_adder u_pc_adder (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc_d)
    );

    // Instructions are word aligned; the low two target bits carry no meaning.
    assign redirect_tgt_d       = {redirect_pc[INSTR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            pc_q          <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        // Flush the slot; the new target issues next cycle.
                        pc_q          <= redirect_tgt_d;
                        instr_valid_q <= 1'b0;
                    end else begin
                        if (instr_valid_q && !stall) begin
                            instr_valid_q <= 1'b0;
                        end
                        // Issue only once the slot is empty or being consumed,
                        // so a returning ack can never find the slot occupied.
                        if (!instr_valid_q || !stall) begin
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= pc_q;
                            state_q     <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        pc_q          <= redirect_tgt_d;
                        instr_valid_q <= 1'b0;
                        if (imem_ack) begin
                            // Data arriving with the redirect is wrong-path.
                            imem_req_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            // Memory still owes a response; hold req/addr and
                            // throw the response away when it comes.
                            state_q <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_pc_q    <= imem_addr_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_inc_d;
                        imem_req_q    <= 1'b0;
                        state_q       <= IDLE;
                    end
                end

                DRAIN: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt_d;
                    end
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;

endmodule
